// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display path: the hex decode table,
// the segments-off pattern, segment bit positions and a polarity helper.
package seg7_pkg;

    // Segment bit positions within {dp,g,f,e,d,c,b,a}
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // All segments dark, active-high sense
    localparam logic [7:0] SEG_OFF = 8'h00;

    // Active-high glyphs for 0..F (lower-case b and d keep them distinct from 8 and 0)
    localparam logic [7:0] DECODE_TABLE [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    // Convert an active-high pattern to the board's drive sense
    function automatic logic [7:0] apply_polarity(input logic [7:0] pattern,
                                                  input logic       active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational nibble-to-glyph decoder; produces an active-high pattern with
// the decimal point forced off, or all segments off when blank is set.
module hex_to_seven_seg
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [7:0] segments
);

    // Table lookup, with the decimal point cleared and blanking taking priority
    always_comb begin
        segments = SEG_OFF;
        if (!blank) begin
            segments         = DECODE_TABLE[nibble];
            segments[SEG_DP] = 1'b0;
        end
    end

endmodule

// File: rtl/top.sv
// Byte to dual hex digit seven-segment driver. Both digits are decoded
// combinationally from Value and captured in a single output register stage,
// so the display follows Value with one clock of latency.
module top
    import seg7_pkg::*;
#(
    parameter int ACTIVE_LOW         = 0,
    parameter int BLANK_LEADING_ZERO = 0
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Value,
    output logic [7:0] SevenSegDig1,
    output logic [7:0] SevenSegDig2
);

    localparam logic POL_LOW = (ACTIVE_LOW != 0);

    // Segments-off in the board's drive sense; this is also the reset value
    localparam logic [7:0] OFF_DRIVE = POL_LOW ? ~SEG_OFF : SEG_OFF;

    logic       blank_hi;
    logic [7:0] pattern_hi;
    logic [7:0] pattern_lo;
    logic [7:0] dig1_p1;
    logic [7:0] dig2_p1;

    assign blank_hi = (BLANK_LEADING_ZERO != 0) && (Value[7:4] == 4'h0);

    hex_to_seven_seg u_dec_hi (
        .nibble   (Value[7:4]),
        .blank    (blank_hi),
        .segments (pattern_hi)
    );

    // The low digit is never blanked so a value of zero still shows "0"
    hex_to_seven_seg u_dec_lo (
        .nibble   (Value[3:0]),
        .blank    (1'b0),
        .segments (pattern_lo)
    );

    // ---- stage p1: output registers, cleared asynchronously so the display goes dark at once
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            dig1_p1 <= OFF_DRIVE;
            dig2_p1 <= OFF_DRIVE;
        end else begin
            dig1_p1 <= apply_polarity(pattern_hi, POL_LOW);
            dig2_p1 <= apply_polarity(pattern_lo, POL_LOW);
        end
    end

    assign SevenSegDig1 = dig1_p1;
    assign SevenSegDig2 = dig2_p1;

endmodule

// File: tb/tb_top.sv
// Bench for top: three instances (default, active-low, leading-zero blanking)
// share one Value stream; expected patterns are queued when Value is driven
// and compared after the capturing clock edge.
module tb_top;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] Value = 8'h00;

    logic [7:0] d1_n, d2_n, d1_al, d2_al, d1_bz, d2_bz;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] n1, n2, a1, a2, b1, b2;
    } exp_t;

    exp_t sb[$];

    localparam logic [7:0] REF [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    top #(.ACTIVE_LOW(0), .BLANK_LEADING_ZERO(0)) u_norm (
        .Clock(Clock), .Reset(Reset), .Value(Value),
        .SevenSegDig1(d1_n), .SevenSegDig2(d2_n));

    top #(.ACTIVE_LOW(1), .BLANK_LEADING_ZERO(0)) u_al (
        .Clock(Clock), .Reset(Reset), .Value(Value),
        .SevenSegDig1(d1_al), .SevenSegDig2(d2_al));

    top #(.ACTIVE_LOW(0), .BLANK_LEADING_ZERO(1)) u_bz (
        .Clock(Clock), .Reset(Reset), .Value(Value),
        .SevenSegDig1(d1_bz), .SevenSegDig2(d2_bz));

    always #5 Clock = ~Clock;

    function automatic exp_t model(input logic [7:0] v);
        exp_t e;
        logic [7:0] hi, lo;
        hi   = REF[v[7:4]];
        lo   = REF[v[3:0]];
        e.n1 = hi;
        e.n2 = lo;
        e.a1 = ~hi;
        e.a2 = ~lo;
        e.b1 = (v[7:4] == 4'h0) ? 8'h00 : hi;
        e.b2 = lo;
        return e;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e.n1 = 8'h00; e.n2 = 8'h00;
        e.a1 = 8'hFF; e.a2 = 8'hFF;
        e.b1 = 8'h00; e.b2 = 8'h00;
        return e;
    endfunction

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check8({tag, "_dig1"},    d1_n,  e.n1);
        check8({tag, "_dig2"},    d2_n,  e.n2);
        check8({tag, "_al_dig1"}, d1_al, e.a1);
        check8({tag, "_al_dig2"}, d2_al, e.a2);
        check8({tag, "_bz_dig1"}, d1_bz, e.b1);
        check8({tag, "_bz_dig2"}, d2_bz, e.b2);
    endtask

    task automatic pop_check(input string tag);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            check_all(tag, sb.pop_front());
        end
    endtask

    // Drive one value on the falling edge, check it after the next rising edge
    task automatic step(input logic [7:0] v);
        string tag;
        @(negedge Clock);
        Value = v;
        sb.push_back(model(v));
        @(posedge Clock);
        #1;
        tag = $sformatf("val_%02h", v);
        pop_check(tag);
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #2 Reset = 1'b1;
        #1;
        check_all("reset_async", reset_exp());
        @(posedge Clock);
        #1;
        check_all("reset_held", reset_exp());
        @(negedge Clock);
        Reset = 1'b0;

        // Basic digit pair and literal patterns
        step(8'h45);
        check8("h45_lit_dig1",    d1_n,  8'b01100110);
        check8("h45_lit_dig2",    d2_n,  8'b01101101);
        check8("h45_lit_al_dig1", d1_al, 8'b10011001);
        check8("h45_lit_al_dig2", d2_al, 8'b10010010);

        // Full sweep, one value per cycle
        for (int i = 0; i < 256; i++) step(8'(i));

        // Leading-zero blanking cases
        step(8'h07);
        check8("blz_07_lit_dig1", d1_bz, 8'h00);
        check8("blz_07_lit_dig2", d2_bz, 8'h07);
        step(8'h10);
        check8("blz_10_lit_dig1", d1_bz, 8'h06);
        check8("blz_10_lit_dig2", d2_bz, 8'h3F);

        // Reset pulsed mid-stream while Value toggles
        step(8'h12);
        step(8'h34);
        step(8'h12);
        @(posedge Clock);
        #2 Reset = 1'b1;
        #1;
        check_all("midreset_async", reset_exp());
        @(negedge Clock);
        Value = 8'h34;
        @(posedge Clock);
        #1;
        check_all("midreset_held", reset_exp());
        @(negedge Clock);
        Reset = 1'b0;
        Value = 8'h34;
        sb.push_back(model(8'h34));
        @(posedge Clock);
        #1;
        pop_check("post_release_34");
        step(8'h12);
        step(8'h34);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
